// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader between a byte stream source (e.g. a UART receiver) and
//   the instruction memory write port. It receives a framed program,
//   assembles little-endian 32-bit words, writes them to memory, and holds
//   the CPU in reset until the whole frame has passed its XOR checksum.
//
//   Frame: COUNT_LO, COUNT_HI, N x 4 payload bytes (LSB first), CHK.
//   CHK is the XOR of every preceding byte in the frame.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          synchronous active-high reset
//   RxData         incoming stream byte
//   RxValid        RxData valid this cycle
//   RxReady        loader can accept a byte (accept = RxValid && RxReady)
//   MemWriteEnable one-cycle instruction memory write strobe
//   MemAddress     byte address of the written word (multiple of 4)
//   MemWriteData   assembled instruction word
//   CPUReset       CPU datapath reset, high until a verified load completes
//   Done           sticky: load complete and checksum matched
//   Error          sticky: frame rejected (oversize count or bad checksum)

module program_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CPUReset,
  output logic        Done,
  output logic        Error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_lo_q;
  logic [15:0] count_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] word_idx_q;
  logic [7:0]  chk_q;
  // Lower three bytes of the word under assembly; the top byte goes
  // straight from RxData into the write data register.
  logic [23:0] asm_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic [15:0] count_d;
  logic [7:0]  chk_d;
  logic        last_word;

  // RxReady is decoded from state so it drops together with Done/Error.
  always_comb begin
    RxReady = 1'b0;
    case (state_q)
      S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK: RxReady = 1'b1;
      default:                             RxReady = 1'b0;
    endcase
  end

  always_comb begin
    accept    = RxValid && RxReady;
    count_d   = {RxData, cnt_lo_q};
    chk_d     = chk_q ^ RxData;
    last_word = (word_idx_q == (count_q - 16'd1));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_CNT_LO;
      cnt_lo_q    <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      chk_q       <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_CNT_LO: begin
            chk_q    <= chk_d;
            cnt_lo_q <= RxData;
            state_q  <= S_CNT_HI;
          end

          S_CNT_HI: begin
            chk_q   <= chk_d;
            count_q <= count_d;
            if (count_d > MAX_N) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (count_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end

          S_DATA: begin
            chk_q      <= chk_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= RxData;
              2'd1: asm_q[15:8]  <= RxData;
              2'd2: asm_q[23:16] <= RxData;
              default: begin
                // Fourth byte: issue the write now; the next byte (or CHK)
                // can be accepted while the strobe is high.
                we_q       <= 1'b1;
                addr_q     <= {14'd0, word_idx_q, 2'b00};
                wdata_q    <= {RxData, asm_q};
                word_idx_q <= word_idx_q + 16'd1;
                if (last_word) begin
                  state_q <= S_CHECK;
                end
              end
            endcase
          end

          S_CHECK: begin
            if (RxData == chk_q) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign MemWriteEnable = we_q;
  assign MemAddress     = addr_q;
  assign MemWriteData   = wdata_q;
  assign CPUReset       = cpu_reset_q;
  assign Done           = done_q;
  assign Error          = error_q;

endmodule
